logbar_frame_sequencer: RTL and testbench
=========================================

// Module: logbar_frame_sequencer
// PURPOSE
//  Initiator side of the log-bar converter handshake (Start/In -> Busy/End/Out).
//  On each FrameStart, walks every FFT bin of the frame RAM and feeds each bin to the converter.
//  Collects each 7-bit bar height, applies clamp and fall-off decay, and writes it to the bar RAM.
//  Sits between the FFT magnitude RAM and the display bar RAM.
// PARAMETERS
//  bw_input    18  bin magnitude width; also the converter input width
//  bw_addr     6   bin/bar address width
//  n_bins      64  bins per frame; 1..2**bw_addr
//  decay_step  2   bar fall per frame; 0 disables decay
//  timeout     31  max cycles from LbStart to LbEnd before abort; 1..255
// PORTS
//  Clock       in   1         system clock; everything on posedge
//  nReset      in   1         asynchronous reset, active-low
//  FrameStart  in   1         1-cycle pulse: process one frame
//  BinAddr     out  bw_addr   frame RAM read address
//  BinData     in   bw_input  frame RAM read data, valid 1 cycle after BinAddr
//  LbStart     out  1         converter start pulse
//  LbIn        out  bw_input  converter input, held stable from LbStart until LbEnd
//  LbBusy      in   1         converter busy
//  LbEnd       in   1         converter done pulse; LbOut valid in this cycle
//  LbOut       in   7         converter bar height
//  BarAddr     out  bw_addr   bar RAM address, used for both read and write
//  BarRdData   in   7         bar RAM read data, valid 1 cycle after BarAddr
//  BarWe       out  1         bar RAM write strobe
//  BarData     out  7         bar RAM write data
//  FrameBusy   out  1         high from the cycle after FrameStart until FrameDone
//  FrameDone   out  1         1-cycle pulse when the last bar is written
//  Error       out  1         sticky timeout flag; cleared by next accepted FrameStart
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; bin index 0. Reset mid-frame aborts at once; no resume.
//  FSM states: IDLE -> RDREQ -> RDWAIT -> START -> WAIT -> WRITE -> (RDREQ | DONE) -> IDLE.
//  IDLE: accept FrameStart only here. On acceptance:
//   - idx<=0; Error<=0; FrameBusy<=1.
//   - FrameStart arriving in any other state is ignored.
//  RDREQ: BinAddr=BarAddr=idx (both held through WRITE).
//  RDWAIT: latch LbIn<=BinData and old<=BarRdData.
//  START: wait while LbBusy=1. When LbBusy=0, assert LbStart for exactly 1 cycle; tmo<=0.
//  WAIT:
//   - On LbEnd: latch h = (LbOut>96) ? 96 : LbOut.
//   - If LbEnd has not arrived by cycle tmo=timeout: h=0; Error<=1.
//   - LbEnd in the same cycle as the timeout: LbEnd wins.
//  WRITE: BarWe=1 for 1 cycle. BarData = max(h, sat0(old-decay_step)).
//   - sat0 clamps underflow to 0; 8-bit internal compare; result always <=96.
//   - Then: if idx==n_bins-1 go to DONE, else idx<=idx+1 and go to RDREQ.
//  DONE: FrameDone=1 for 1 cycle; FrameBusy<=0; return to IDLE.
//  Per-bin cost: 5 cycles + converter latency (LbStart to LbEnd).
//  LbStart never asserts while LbBusy=1. At most one conversion is outstanding.
//  LbEnd seen outside WAIT is ignored.
//  BarWe is never asserted outside WRITE, so exactly n_bins writes occur per frame.
// TESTING
//  1. n_bins=4; converter model (4-cycle latency) returns 10,20,30,40; bar RAM all 0.
//     -> bar RAM = 10,20,30,40; FrameDone 1 pulse; 4 BarWe pulses.
//  2. Old bar 50, LbOut 20, decay_step=2 -> BarData 48.
//     Old bar 1 -> BarData = LbOut. Old bar 0, LbOut 0 -> BarData 0.
//  3. LbOut=127 -> BarData 96. LbOut=96 -> BarData 96.
//  4. Converter never returns LbEnd on bin 2 -> after 31 WAIT cycles:
//     bar2 written as 0 (with no decay floor above it); Error=1; frame completes.
//     Next FrameStart clears Error.
//  5. LbBusy held high 10 cycles on entry to START -> LbStart is delayed 10 cycles.
//     A FrameStart pulse mid-frame is ignored.
//  6. nReset low mid-WAIT -> all outputs 0 next edge.
//     FrameStart after release processes from bin 0.

Source files
------------

// File: rtl/logbar_frame_sequencer_if.sv
// Bus bundle between the frame sequencer and its three neighbours: the FFT
// frame RAM (read only), the log-bar converter (Start/In -> Busy/End/Out)
// and the display bar RAM (shared read/write address).
interface logbar_frame_sequencer_if #(
  parameter int bw_input = 18,
  parameter int bw_addr  = 6
);
  logic [bw_addr-1:0]  BinAddr;
  logic [bw_input-1:0] BinData;
  logic                LbStart;
  logic [bw_input-1:0] LbIn;
  logic                LbBusy;
  logic                LbEnd;
  logic [6:0]          LbOut;
  logic [bw_addr-1:0]  BarAddr;
  logic [6:0]          BarRdData;
  logic                BarWe;
  logic [6:0]          BarData;

  // Sequencer side
  modport master (
    output BinAddr, input  BinData,
    output LbStart, output LbIn, input LbBusy, input LbEnd, input LbOut,
    output BarAddr, input  BarRdData, output BarWe, output BarData
  );

  // RAM / converter side
  modport slave (
    input  BinAddr, output BinData,
    input  LbStart, input  LbIn, output LbBusy, output LbEnd, output LbOut,
    input  BarAddr, output BarRdData, input BarWe, input BarData
  );
endinterface

// File: rtl/logbar_frame_sequencer.sv
// Frame sequencer: on FrameStart walks every FFT bin, runs it through the
// log-bar converter, clamps the height to 96, applies fall-off decay against
// the previous bar and writes the result back to the bar RAM.
module logbar_frame_sequencer #(
  parameter int bw_input   = 18,
  parameter int bw_addr    = 6,
  parameter int n_bins     = 64,
  parameter int decay_step = 2,
  parameter int timeout    = 31
) (
  input  logic Clock,
  input  logic nReset,
  input  logic FrameStart,
  logbar_frame_sequencer_if.master Bus,
  output logic FrameBusy,
  output logic FrameDone,
  output logic Error
);

  typedef enum logic [2:0] {
    stIdle, stRdReq, stRdWait, stStart, stWait, stWrite, stDone
  } stateT;

  localparam logic [bw_addr-1:0] lastIdx  = bw_addr'(n_bins - 1);
  localparam logic [7:0]         tmoLimit = 8'(timeout);
  localparam logic [7:0]         decayW   = 8'(decay_step);
  localparam logic [6:0]         barMax   = 7'd96;

  stateT               state, nextState;
  logic [bw_addr-1:0]  idx;
  logic [bw_input-1:0] lbInReg;
  logic [6:0]          oldBar;
  logic [6:0]          height;
  logic [7:0]          tmo;

  logic [7:0]          oldExt;
  logic [7:0]          decayed;
  logic [6:0]          maxBar;
  logic [6:0]          newBar;

  // Decayed previous bar (floored at 0), max against the new height, cap at 96.
  // A stale bar RAM value above 96 is capped too, so writes never exceed 96.
  always_comb begin
    oldExt  = {1'b0, oldBar};
    decayed = (oldExt >= decayW) ? (oldExt - decayW) : 8'd0;
    maxBar  = ({1'b0, height} >= decayed) ? height : decayed[6:0];
    newBar  = (maxBar > barMax) ? barMax : maxBar;
  end

  // State register
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state <= stIdle;
    else         state <= nextState;
  end

  // Next-state logic; FrameStart is only honoured in idle
  always_comb begin
    nextState = state;
    case (state)
      stIdle:   if (FrameStart) nextState = stRdReq;
      stRdReq:  nextState = stRdWait;
      stRdWait: nextState = stStart;
      stStart:  if (!Bus.LbBusy) nextState = stWait;
      stWait:   if (Bus.LbEnd || tmo == tmoLimit) nextState = stWrite;
      stWrite:  nextState = (idx == lastIdx) ? stDone : stRdReq;
      stDone:   nextState = stIdle;
      default:  nextState = stIdle;
    endcase
  end

  // Outputs; addresses follow idx so they stay put from RDREQ through WRITE
  always_comb begin
    Bus.BinAddr = idx;
    Bus.BarAddr = idx;
    Bus.LbIn    = lbInReg;
    Bus.LbStart = 1'b0;
    Bus.BarWe   = 1'b0;
    Bus.BarData = 7'd0;
    FrameDone   = 1'b0;
    case (state)
      stStart: Bus.LbStart = !Bus.LbBusy;
      stWrite: begin
        Bus.BarWe   = 1'b1;
        Bus.BarData = newBar;
      end
      stDone:  FrameDone = 1'b1;
      default: ;
    endcase
  end

  // Datapath: bin index, latched operands, timeout counter, status flags
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      idx       <= '0;
      lbInReg   <= '0;
      oldBar    <= '0;
      height    <= '0;
      tmo       <= '0;
      Error     <= 1'b0;
      FrameBusy <= 1'b0;
    end else begin
      case (state)
        stIdle: if (FrameStart) begin
          idx       <= '0;
          Error     <= 1'b0;
          FrameBusy <= 1'b1;
        end
        stRdWait: begin
          lbInReg <= Bus.BinData;
          oldBar  <= Bus.BarRdData;
        end
        stStart: if (!Bus.LbBusy) tmo <= '0;
        stWait: begin
          // A result landing on the timeout cycle still counts
          if (Bus.LbEnd) begin
            height <= (Bus.LbOut > barMax) ? barMax : Bus.LbOut;
          end else if (tmo == tmoLimit) begin
            height <= '0;
            Error  <= 1'b1;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        stWrite: if (idx != lastIdx) idx <= idx + 1'b1;
        stDone:  FrameBusy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logbar_frame_sequencer.sv
// Bench for logbar_frame_sequencer: 4-bin frames against a frame RAM, a bar
// RAM and a 4-cycle converter model whose output is LbIn[6:0]. An LbIn with
// bit 17 set is swallowed by the converter and never answered.
module tb_logbar_frame_sequencer;

  localparam int NB    = 4;
  localparam int CvLat = 4;

  logic Clock = 1'b0;
  logic nReset;
  logic FrameStart;
  logic FrameBusy, FrameDone, Error;

  logbar_frame_sequencer_if #(.bw_input(18), .bw_addr(6)) bus();

  logbar_frame_sequencer #(
    .bw_input(18), .bw_addr(6), .n_bins(NB), .decay_step(2), .timeout(31)
  ) dut (
    .Clock(Clock), .nReset(nReset), .FrameStart(FrameStart), .Bus(bus),
    .FrameBusy(FrameBusy), .FrameDone(FrameDone), .Error(Error)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Frame RAM and bar RAM models, synchronous read
  logic [17:0] binMem [64];
  logic [6:0]  barMem [64];
  logic [6:0]  barInit [64];
  logic        loadBars;

  always @(posedge Clock) bus.BinData <= binMem[bus.BinAddr];

  always @(posedge Clock) begin
    bus.BarRdData <= barMem[bus.BarAddr];
    if (loadBars) begin
      for (int i = 0; i < 64; i++) barMem[i] <= barInit[i];
    end else if (bus.BarWe) begin
      barMem[bus.BarAddr] <= bus.BarData;
    end
  end

  // Converter model
  logic        cvActive;
  logic [7:0]  cvCnt;
  logic [17:0] cvIn;
  logic        extBusy;

  assign bus.LbBusy = cvActive | extBusy;

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      cvActive   <= 1'b0;
      cvCnt      <= '0;
      cvIn       <= '0;
      bus.LbEnd  <= 1'b0;
      bus.LbOut  <= '0;
    end else begin
      bus.LbEnd <= 1'b0;
      if (bus.LbStart) begin
        cvActive <= 1'b1;
        cvCnt    <= 8'd1;
        cvIn     <= bus.LbIn;
      end else if (cvActive) begin
        if (cvIn[17]) begin
          cvActive <= 1'b0;
        end else if (cvCnt == 8'(CvLat - 1)) begin
          cvActive  <= 1'b0;
          bus.LbEnd <= 1'b1;
          bus.LbOut <= cvIn[6:0];
        end else begin
          cvCnt <= cvCnt + 8'd1;
        end
      end
    end
  end

  // Event counters and protocol watch
  int weCnt = 0, doneCnt = 0, protoErr = 0;
  always @(posedge Clock) begin
    if (bus.BarWe) weCnt <= weCnt + 1;
    if (FrameDone) doneCnt <= doneCnt + 1;
    if (bus.LbStart && bus.LbBusy) protoErr <= protoErr + 1;
  end

  typedef struct packed {
    logic [3:0][17:0] bin;
    logic [3:0][6:0]  old;
    logic [3:0][6:0]  exp;
    logic             expErr;
  } vecT;

  vecT vecs [5];

  function automatic vecT mkVec(input int b0, b1, b2, b3, o0, o1, o2, o3,
                                input int e0, e1, e2, e3, input bit err);
    vecT v;
    v.bin[0] = 18'(b0); v.bin[1] = 18'(b1); v.bin[2] = 18'(b2); v.bin[3] = 18'(b3);
    v.old[0] = 7'(o0);  v.old[1] = 7'(o1);  v.old[2] = 7'(o2);  v.old[3] = 7'(o3);
    v.exp[0] = 7'(e0);  v.exp[1] = 7'(e1);  v.exp[2] = 7'(e2);  v.exp[3] = 7'(e3);
    v.expErr = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic loadVec(input vecT v);
    for (int i = 0; i < NB; i++) begin
      binMem[i]  = v.bin[i];
      barInit[i] = v.old[i];
    end
    loadBars = 1'b1;
    tick();
    loadBars = 1'b0;
  endtask

  // Returns one cycle after the accepting edge
  task automatic startFrame();
    FrameStart = 1'b1;
    tick();
    FrameStart = 1'b0;
  endtask

  task automatic waitDone(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (FrameDone) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic checkResult(input string tag, input vecT v, input int w0, input int d0, input bit ok);
    check({tag, " done_seen"}, 32'(ok), 32'd1);
    check({tag, " busy_after"}, 32'(FrameBusy), 32'd0);
    check({tag, " error"}, 32'(Error), 32'(v.expErr));
    for (int i = 0; i < NB; i++)
      check($sformatf("%s bar%0d", tag, i), 32'(barMem[i]), 32'(v.exp[i]));
    check({tag, " we_count"}, 32'(weCnt - w0), 32'(NB));
    check({tag, " done_count"}, 32'(doneCnt - d0), 32'd1);
  endtask

  task automatic runVec(input string tag, input vecT v);
    int w0, d0;
    bit ok;
    loadVec(v);
    w0 = weCnt;
    d0 = doneCnt;
    startFrame();
    check({tag, " busy_start"}, 32'(FrameBusy), 32'd1);
    check({tag, " error_clr"}, 32'(Error), 32'd0);
    waitDone(ok);
    checkResult(tag, v, w0, d0, ok);
  endtask

  initial begin
    int firstStart, starts, w0, d0;
    bit ok;

    nReset = 1'b0; FrameStart = 1'b0; extBusy = 1'b0; loadBars = 1'b0;
    for (int i = 0; i < 64; i++) begin
      binMem[i] = '0; barMem[i] = '0; barInit[i] = '0;
    end

    vecs[0] = mkVec(10, 20, 30, 40,       0, 0, 0, 0,     10, 20, 30, 40, 1'b0);
    vecs[1] = mkVec(20, 5, 0, 7,          50, 1, 0, 9,    48, 5, 0, 7,    1'b0);
    vecs[2] = mkVec(127, 96, 97, 0,       0, 0, 0, 100,   96, 96, 96, 96, 1'b0);
    vecs[3] = mkVec(10, 20, 'h20000, 40,  0, 0, 0, 0,     10, 20, 0, 40,  1'b1);
    vecs[4] = mkVec(3, 0, 64, 90,         5, 60, 64, 2,   3, 58, 64, 90,  1'b0);

    repeat (3) tick();
    check("rst FrameBusy", 32'(FrameBusy), 32'd0);
    check("rst FrameDone", 32'(FrameDone), 32'd0);
    check("rst Error", 32'(Error), 32'd0);
    check("rst LbStart", 32'(bus.LbStart), 32'd0);
    check("rst BarWe", 32'(bus.BarWe), 32'd0);
    check("rst BarData", 32'(bus.BarData), 32'd0);
    check("rst LbIn", 32'(bus.LbIn), 32'd0);
    check("rst BinAddr", 32'(bus.BinAddr), 32'd0);
    nReset = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) runVec($sformatf("vec%0d", v), vecs[v]);

    // Converter busy for 10 cycles on entry to START delays the first start;
    // a FrameStart pulse mid-frame must not restart anything.
    loadVec(vecs[0]);
    w0 = weCnt;
    d0 = doneCnt;
    extBusy = 1'b1;
    startFrame();
    firstStart = -1;
    for (int c = 1; c <= 20; c++) begin
      if (c == 13) extBusy = 1'b0;
      if (c == 6) FrameStart = 1'b1;
      if (c == 7) FrameStart = 1'b0;
      #1;
      if (bus.LbStart && firstStart < 0) firstStart = c;
      tick();
    end
    extBusy = 1'b0;
    FrameStart = 1'b0;
    check("busy first_start_cycle", 32'(firstStart), 32'd13);
    waitDone(ok);
    checkResult("busy", vecs[0], w0, d0, ok);

    // Reset while waiting on bin 2, then a clean frame from bin 0
    loadVec(vecs[1]);
    startFrame();
    starts = 0;
    for (int n = 0; n < 200; n++) begin
      if (bus.LbStart) starts++;
      if (starts == 3) break;
      tick();
    end
    check("rstmid third_start", 32'(starts), 32'd3);
    tick();
    tick();
    check("rstmid bin_before", 32'(bus.BinAddr), 32'd2);
    nReset = 1'b0;
    #1;
    check("rstmid FrameBusy", 32'(FrameBusy), 32'd0);
    check("rstmid LbIn", 32'(bus.LbIn), 32'd0);
    check("rstmid BinAddr", 32'(bus.BinAddr), 32'd0);
    tick();
    check("rstmid LbStart", 32'(bus.LbStart), 32'd0);
    check("rstmid BarWe", 32'(bus.BarWe), 32'd0);
    check("rstmid FrameDone", 32'(FrameDone), 32'd0);
    nReset = 1'b1;
    tick();
    runVec("afterrst", vecs[1]);

    check("no start while busy", 32'(protoErr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
